// File: rtl/crc3_pkg.sv
// Shared constants for the CRC-3 serial stages: frame geometry, generator
// polynomial and FSM state encodings.
package crc3_pkg;
   localparam int MSG_LENGTH        = 17;
   localparam int POLINOMIAL_LENGTH = 4;
   localparam logic [POLINOMIAL_LENGTH-1:0] POLINOM = 4'b1011;

   localparam int DATA_LENGTH = MSG_LENGTH - POLINOMIAL_LENGTH + 1;
   localparam int CRC_LENGTH  = POLINOMIAL_LENGTH - 1;
   localparam int CNT_WIDTH   = $clog2(MSG_LENGTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/crc3_lfsr_step.sv
// One bit of serial polynomial division: shift the bit into the remainder and
// subtract (xor) the generator whenever the outgoing MSB is set.
module crc3_lfsr_step #(
   parameter int W = 3
) (
   input  logic [W-1:0] r_i,
   input  logic         bit_i,
   input  logic [W-1:0] poly_i,
   output logic [W-1:0] r_next_o
);
   assign r_next_o = {r_i[W-2:0], bit_i} ^ (r_i[W-1] ? poly_i : '0);
endmodule

// File: rtl/crc3_serial_checker.sv
// Serial CRC-3 checker: divides a 17-bit MSB-first codeword by the generator and
// reports pass/fail plus the recovered data. Define CRC_ERR_CNT_EN for an error counter.
module crc3_serial_checker
   import crc3_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bit_in,
   input  logic                   bit_valid,
   input  logic                   sof,
   output logic                   in_ready,
   output logic                   done,
   output logic                   crc_ok,
   output logic [DATA_LENGTH-1:0] data_out,
   output logic [CRC_LENGTH-1:0]  syndrome
`ifdef CRC_ERR_CNT_EN
   ,
   output logic [7:0]             err_cnt,
   output logic                   err_cnt_sat
`endif
);
   logic [1:0]             state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CRC_LENGTH-1:0]  rem_q, rem_d;
   logic [CRC_LENGTH-1:0]  step_r, step_out;
   logic [DATA_LENGTH-1:0] data_sr_q, data_sr_d;
   logic [DATA_LENGTH-1:0] data_out_q;
   logic [CRC_LENGTH-1:0]  syndrome_q;
   logic                   crc_ok_q;
   logic                   accept, restart, last_bit;

   assign in_ready = rst_n && (state_q != ST_DONE);
   assign accept   = bit_valid && in_ready;
   assign restart  = accept && sof;
   assign last_bit = accept && !sof && (state_q == ST_SHIFT)
                     && (cnt_q == CNT_WIDTH'(MSG_LENGTH - 1));

   // A frame start divides against an empty remainder, discarding any partial frame.
   assign step_r = restart ? '0 : rem_q;

   crc3_lfsr_step #(.W(CRC_LENGTH)) u_step (
      .r_i      (step_r),
      .bit_i    (bit_in),
      .poly_i   (POLINOM[CRC_LENGTH-1:0]),
      .r_next_o (step_out)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      data_sr_d = data_sr_q;
      case (state_q)
         ST_IDLE, ST_SHIFT: begin
            if (restart) begin
               state_d   = ST_SHIFT;
               cnt_d     = CNT_WIDTH'(1);
               rem_d     = step_out;
               data_sr_d = DATA_LENGTH'(bit_in);
            end else if (accept && state_q == ST_SHIFT) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
               rem_d = step_out;
               if (cnt_q < CNT_WIDTH'(DATA_LENGTH))
                  data_sr_d = {data_sr_q[DATA_LENGTH-2:0], bit_in};
               if (last_bit)
                  state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         data_sr_q  <= '0;
         data_out_q <= '0;
         syndrome_q <= '0;
         crc_ok_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         data_sr_q <= data_sr_d;
         // Results land on the last-bit edge so they are valid in the DONE cycle.
         if (last_bit) begin
            syndrome_q <= step_out;
            crc_ok_q   <= (step_out == '0);
            data_out_q <= data_sr_q;
         end
      end
   end

   assign done     = (state_q == ST_DONE);
   assign crc_ok   = crc_ok_q;
   assign data_out = data_out_q;
   assign syndrome = syndrome_q;

`ifdef CRC_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         err_cnt_q <= '0;
      else if (last_bit && (step_out != '0) && (err_cnt_q != 8'hFF))
         err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_cnt     = err_cnt_q;
   assign err_cnt_sat = (err_cnt_q == 8'hFF);
`endif
endmodule

// File: tb/tb_crc3_serial_checker.sv
// Directed plus randomized bench for crc3_serial_checker; the reference is a
// plain polynomial long division of the whole codeword.
module tb_crc3_serial_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic sof = 1'b0;
   logic in_ready, done, crc_ok;
   logic [13:0] data_out;
   logic [2:0] syndrome;
`ifdef CRC_ERR_CNT_EN
   logic [7:0] err_cnt;
   logic err_cnt_sat;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int first_cyc = 0;
   int exp_err = 0;
   int stall_before[17];

   localparam logic [3:0]  GEN  = 4'b1011;
   localparam logic [16:0] GOOD = 17'b11010011101100100;
   localparam logic [16:0] BAD5 = 17'b11011011101100100;

   crc3_serial_checker dut (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .in_ready(in_ready), .done(done), .crc_ok(crc_ok),
      .data_out(data_out), .syndrome(syndrome)
`ifdef CRC_ERR_CNT_EN
      , .err_cnt(err_cnt), .err_cnt_sat(err_cnt_sat)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Long division over GF(2): cancel every set bit above the remainder field.
   function automatic logic [2:0] ref_rem(input logic [16:0] cw);
      logic [16:0] t;
      t = cw;
      for (int i = 16; i >= 3; i--)
         if (t[i]) t = t ^ (17'(GEN) << (i - 3));
      return t[2:0];
   endfunction

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic clear_stalls;
      for (int i = 0; i < 17; i++) stall_before[i] = 0;
   endtask

   task automatic send_bits(input logic [16:0] cw, input int n, input bit with_sof);
      int guard;
      for (int i = 0; i < n; i++) begin
         for (int s = 0; s < stall_before[i]; s++) begin
            bit_valid = 1'b0; bit_in = 1'($urandom); sof = 1'($urandom);
            tick;
         end
         guard = 0;
         while (in_ready !== 1'b1 && guard < 4) begin
            bit_valid = 1'b0; sof = 1'b0;
            tick;
            guard++;
         end
         if (guard == 4) check("in_ready_timeout", 32'(in_ready), 32'd1);
         bit_valid = 1'b1;
         bit_in = cw[16-i];
         sof = (i == 0) && with_sof;
         if (i == 0) first_cyc = cyc;
         tick;
      end
      bit_valid = 1'b0;
      sof = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [16:0] cw);
      int d0, w, extra;
      logic [2:0] rem;
      d0 = done_cnt;
      extra = 0;
      for (int i = 1; i < 17; i++) extra += stall_before[i];
      send_bits(cw, 17, 1'b1);
      w = 0;
      while (done_cnt == d0 && w < 6) begin
         @(negedge clk); #1;
         w++;
      end
      rem = ref_rem(cw);
      if (rem != 3'd0 && exp_err < 255) exp_err++;
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_latency"}, 32'(last_done_cyc - first_cyc + 1), 32'(18 + extra));
      check({tag, "_crc_ok"}, 32'(crc_ok), 32'(rem == 3'd0));
      check({tag, "_syndrome"}, 32'(syndrome), 32'(rem));
      check({tag, "_data_out"}, 32'(data_out), 32'(cw[16:3]));
`ifdef CRC_ERR_CNT_EN
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
      check({tag, "_err_sat"}, 32'(err_cnt_sat), 32'(exp_err == 255));
`endif
      $display("frame %s cw=%05h syndrome=%0d crc_ok=%0b", tag, cw, syndrome, crc_ok);
   endtask

   initial begin
      int d0;
      logic [16:0] cw;
      clear_stalls();

      // Reset state
      rst_n = 1'b0;
      tick; tick;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_crc_ok", 32'(crc_ok), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_syndrome", 32'(syndrome), 32'd0);
      rst_n = 1'b1;
      tick;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // 1: good frame, no stalls
      run_frame("s1", GOOD);
      check("s1_data_const", 32'(data_out), 32'(14'b11010011101100));

      // 2: bit 5 flipped
      run_frame("s2", BAD5);
      check("s2_syndrome_nonzero", 32'(syndrome != 3'd0), 32'd1);

      // 3: three stall cycles mid-frame
      for (int k = 0; k < 3; k++) stall_before[$urandom_range(1, 16)]++;
      run_frame("s3", GOOD);
      clear_stalls();

      // 4: truncated prefix abandoned by a new sof
      d0 = done_cnt;
      send_bits(GOOD, 8, 1'b1);
      check("s4_prefix_no_done", 32'(done_cnt - d0), 32'd0);
      run_frame("s4", GOOD);
      check("s4_single_done", 32'(done_cnt - d0), 32'd1);

      // 5: pre-sof bits ignored, then reset mid-frame
      d0 = done_cnt;
      for (int k = 0; k < 5; k++) begin
         bit_valid = 1'b1; sof = 1'b0; bit_in = 1'($urandom);
         tick;
      end
      bit_valid = 1'b0;
      tick; tick;
      check("s5_junk_no_done", 32'(done_cnt - d0), 32'd0);
      run_frame("s5a", GOOD);
      d0 = done_cnt;
      send_bits(BAD5, 10, 1'b1);
      rst_n = 1'b0;
      #2;
      check("s5_rst_in_ready", 32'(in_ready), 32'd0);
      tick;
      rst_n = 1'b1;
      exp_err = 0;
      check("s5_rst_crc_ok", 32'(crc_ok), 32'd0);
      check("s5_rst_data_out", 32'(data_out), 32'd0);
      check("s5_rst_syndrome", 32'(syndrome), 32'd0);
`ifdef CRC_ERR_CNT_EN
      check("s5_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
      send_bits(GOOD, 7, 1'b0);
      tick; tick; tick;
      check("s5_reset_frame_no_done", 32'(done_cnt - d0), 32'd0);
      run_frame("s5b", GOOD);

      // Randomized frames, half of them corrupted, with random stalls
      for (int n = 0; n < 24; n++) begin
         cw = {14'($urandom_range(0, 16383)), 3'b000};
         cw[2:0] = ref_rem(cw);
         if ($urandom_range(0, 1) == 1) cw[$urandom_range(0, 16)] ^= 1'b1;
         clear_stalls();
         for (int i = 1; i < 17; i++)
            if ($urandom_range(0, 5) == 0) stall_before[i] = $urandom_range(1, 2);
         run_frame($sformatf("rnd%0d", n), cw);
      end
      clear_stalls();

`ifdef CRC_ERR_CNT_EN
      // 6: saturate the error counter with back-to-back bad frames
      d0 = done_cnt;
      for (int n = 0; n < 260; n++) run_frame($sformatf("sat%0d", n), BAD5);
      check("s6_done_total", 32'(done_cnt - d0), 32'd260);
      check("s6_err_cnt", 32'(err_cnt), 32'hFF);
      check("s6_err_sat", 32'(err_cnt_sat), 32'd1);
      run_frame("s6_good", GOOD);
      check("s6_err_hold", 32'(err_cnt), 32'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/crc3_serial_checker.md
Name: crc3_serial_checker

Overview:
Receive-side stage downstream of the CRC-3 generator (`CRC_int`). Accepts a 17-bit codeword serially, MSB first: 14 data bits followed by 3 CRC bits. It divides the codeword by the generator polynomial with a bit-serial LFSR, then reports pass/fail and the recovered 14-bit data word. A one-cycle done pulse marks the end of each frame.

Parameters:
MSG_LENGTH, 17, codeword length in bits (data + CRC).
POLINOMIAL_LENGTH, 4, generator width; CRC width = POLINOMIAL_LENGTH-1.
POLINOM, 4'b1011, generator polynomial (x^3+x+1); MSB must be 1.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
bit_in  in  1  serial codeword bit, MSB first.
bit_valid  in  1  bit_in is valid this cycle.
sof  in  1  qualifies the first bit of a frame; sampled only when bit_valid=1.
in_ready  out  1  block accepts a bit this cycle.
done  out  1  one-cycle pulse: frame complete, result valid.
crc_ok  out  1  remainder == 0 for the last frame; held until the next done.
data_out  out  MSG_LENGTH-POLINOMIAL_LENGTH+1 (14)  recovered data bits; held until the next done.
syndrome  out  POLINOMIAL_LENGTH-1 (3)  final remainder; held until the next done.

Behaviour:
- Reset (rst_n=0 at a clk edge) puts the block in IDLE and clears the following: in_ready=0 during reset, done=0, crc_ok=0, data_out=0, syndrome=0, bit counter=0, remainder register=0, shift register=0.
- Accept condition: bit_valid && in_ready.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: in_ready=1. An accepted bit with sof=1 loads the first bit and moves to SHIFT with count=1. An accepted bit with sof=0 is discarded and the state stays IDLE.
  - SHIFT: in_ready=1. Each accepted bit updates the LFSR and increments the count. The bit that makes count==MSG_LENGTH moves the state to DONE.
  - SHIFT with an accepted sof=1 bit mid-frame: the partial frame is abandoned with no done pulse. The remainder is reloaded as if from IDLE and count=1.
  - bit_valid=0 in SHIFT: stall, with no state change.
  - DONE: in_ready=0 for exactly one cycle. done=1 with crc_ok, syndrome and data_out updated in the same cycle. The state then returns to IDLE.
- LFSR update per accepted bit, with r[2:0] as the remainder register:
  - fb = r[2]
  - r_next = {r[1:0], bit_in} ^ (fb ? POLINOM[2:0] : 0)
  - The first bit of a frame is applied against r=0.
- The first 14 accepted bits are also shifted into data shift register, MSB first. Bits 15-17 are not stored.
- At DONE: syndrome = r, crc_ok = (r==0), data_out = data shift register.
- Latency: done is asserted the cycle after the 17th bit is accepted. The minimum frame period is 18 cycles.
- Reset mid-frame takes effect at the next edge and produces no done.
- Width rule: the counter is $clog2(MSG_LENGTH+1) bits and never wraps within a frame.

Optional Feature:
- Macro: CRC_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0] and output err_cnt_sat [1].
  - err_cnt increments on each done with crc_ok=0 and saturates at 8'hFF.
  - err_cnt_sat=1 while err_cnt==8'hFF.
  - Both are cleared by rst_n=0.
  - Abandoned frames (sof resync) are not counted.
- Undefined: neither port nor the counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package/include `crc3_pkg`:
  - defines MSG_LENGTH, POLINOMIAL_LENGTH and POLINOM.
  - derived DATA_LENGTH=MSG_LENGTH-POLINOMIAL_LENGTH+1 and CRC_LENGTH=POLINOMIAL_LENGTH-1.
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- One sub-module, `crc3_lfsr_step`:
  - combinational single-bit division step: (r, bit, poly) -> r_next.
  - reused later by a serial generator stage.

Test Plan:
1. Reset, then send 11010011101100100 with sof on bit 1 and bit_valid=1 every cycle. Required: done exactly 18 cycles after the first bit, crc_ok=1, syndrome=3'b000, data_out=14'b11010011101100.
2. Same frame with bit 5 flipped (11011011101100100). Required: done, crc_ok=0, syndrome!=0. With CRC_ERR_CNT_EN defined, err_cnt=1.
3. Same good frame with bit_valid deasserted for 3 random cycles mid-frame. Required: done 21 cycles after the first bit, crc_ok=1, result identical to scenario 1.
4. Send 8 bits, then assert sof and send the full good frame. Required: exactly one done, crc_ok=1, no done after the truncated prefix.
5. Bits with sof=0 in IDLE, then rst_n=0 for one cycle mid-frame, then a good frame. Required: pre-sof bits ignored, no done from the reset frame, all outputs zero after reset, then crc_ok=1.
6. With CRC_ERR_CNT_EN defined, 260 back-to-back bad frames. Required: err_cnt=8'hFF, err_cnt_sat=1. A subsequent good frame leaves err_cnt unchanged.
